// File: rtl/apb_arb_master.sv
// -----------------------------------------------------------------------------
// apb_arb_master
//
// Shares one APB completer port between NUM_REQ internal requesters. A
// round-robin arbiter picks one pending request while the bus is idle, the FSM
// walks the APB SETUP and ACCESS phases, and the result (read data or a
// timeout error) is returned to the requester that won the grant.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge) and asynchronous active-low reset
//   req_valid/req_write  per-requester request and direction (1 = write)
//   req_addr/req_wdata   packed per-requester address / write data,
//                        requester i at [i*W +: W]
//   req_ready            one-cycle accept pulse to the granted requester
//   rsp_valid            one-cycle completion pulse to the owning requester
//   rsp_rdata/rsp_err    read data / timeout flag, qualified by rsp_valid
//   PSEL..PWDATA         APB request outputs (all registered)
//   PRDATA/PREADY        APB completer response inputs
// -----------------------------------------------------------------------------
module apb_arb_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY
);

    localparam int GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [GNT_W-1:0]      last_grant, last_grant_nxt;
    logic [GNT_W-1:0]      owner, owner_nxt;
    logic [GNT_W-1:0]      grant;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_nxt;
    logic                  timeout_hit;

    logic                  psel_nxt;
    logic                  penable_nxt;
    logic                  pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic [NUM_REQ-1:0]    req_ready_nxt;
    logic [NUM_REQ-1:0]    rsp_valid_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                  rsp_err_nxt;

    // Round-robin pick: first asserted index after 'last', wrapping. The loop
    // runs from the lowest priority (last itself) to the highest (last+1) so
    // the highest-priority hit is the one that sticks.
    function automatic logic [GNT_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                                 input logic [GNT_W-1:0]   last);
        logic [GNT_W-1:0] pick;
        int               idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (valid[idx]) begin
                pick = GNT_W'(idx);
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [GNT_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    // The counter holds the number of stalled ACCESS cycles already seen, so
    // reaching TIMEOUT-1 while PREADY is still low means this is the
    // TIMEOUT-th stalled cycle.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        wait_cnt_nxt   = wait_cnt;
        psel_nxt       = PSEL;
        penable_nxt    = PENABLE;
        pwrite_nxt     = PWRITE;
        paddr_nxt      = PADDR;
        pwdata_nxt     = PWDATA;
        req_ready_nxt  = '0;
        rsp_valid_nxt  = '0;
        rsp_rdata_nxt  = '0;
        rsp_err_nxt    = 1'b0;
        grant          = rr_pick(req_valid, last_grant);

        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (|req_valid) begin
                    state_nxt      = SETUP;
                    owner_nxt      = grant;
                    last_grant_nxt = grant;
                    psel_nxt       = 1'b1;
                    pwrite_nxt     = req_write[grant];
                    paddr_nxt      = req_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
                    pwdata_nxt     = req_wdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                    req_ready_nxt  = onehot(grant);
                end
            end

            SETUP: begin
                state_nxt    = ACCESS;
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
            end

            ACCESS: begin
                // A ready completer wins over a timeout landing on the same cycle.
                if (PREADY) begin
                    state_nxt     = IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = onehot(owner);
                    rsp_rdata_nxt = PWRITE ? '0 : PRDATA;
                end else if (timeout_hit) begin
                    state_nxt     = IDLE;
                    psel_nxt      = 1'b0;
                    penable_nxt   = 1'b0;
                    rsp_valid_nxt = onehot(owner);
                    rsp_err_nxt   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            last_grant <= GNT_W'(NUM_REQ - 1);
            owner      <= '0;
            wait_cnt   <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            wait_cnt   <= wait_cnt_nxt;
            PSEL       <= psel_nxt;
            PENABLE    <= penable_nxt;
            PWRITE     <= pwrite_nxt;
            PADDR      <= paddr_nxt;
            PWDATA     <= pwdata_nxt;
            req_ready  <= req_ready_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_rdata  <= rsp_rdata_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_apb_arb_master.sv
// -----------------------------------------------------------------------------
// tb_apb_arb_master
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model (round-robin choice over the requesters seen valid, a flat
// memory image of the completer, per-transfer latency from the chosen stall
// count) predicts every grant, every APB cycle and every response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_arb_master;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b1;
    logic [NR-1:0] req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0] rsp_rdata, PWDATA, PRDATA;
    logic          rsp_err, PSEL, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;

    // requester-side stimulus
    logic [NR-1:0] rv = '0;
    logic [NR-1:0] rw = '0;
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] rd [NR];

    assign req_valid = rv;
    assign req_write = rw;
    assign req_addr  = {ra[1], ra[0]};
    assign req_wdata = {rd[1], rd[0]};

    apb_arb_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 PCLK = ~PCLK;

    // APB completer stub: 16 words, PREADY after stall_cfg stalled cycles.
    logic [DW-1:0] mem [16];
    int            stall_cfg = 0;
    int            wcnt;

    assign PREADY = PSEL && PENABLE && (wcnt >= stall_cfg);
    assign PRDATA = mem[PADDR];

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wcnt <= 0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (PSEL && PENABLE) begin
            if (PREADY) begin
                wcnt <= 0;
                if (PWRITE) mem[PADDR] <= PWDATA;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    // reference model state
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    bit            busy = 0;
    int            m_last = NR - 1;
    logic [DW-1:0] m_mem [16];
    int            p_owner, p_due;
    bit            p_err, p_write;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_data;
    logic [DW-1:0] last_rdata;
    bit            last_err;
    int            grants [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // One clock: sample #1 after the edge, check against the model, then let
    // requesters drop a request that has just been accepted.
    task automatic tick();
        logic [NR-1:0] pv;
        bit            was_idle;
        int            w, nacc;
        logic [63:0]   exp_rdy;
        pv = rv;
        was_idle = !busy;
        @(posedge PCLK);
        #1;
        cyc++;

        if (busy && cyc == p_due) begin
            chk("rsp_valid", rsp_valid, 64'(1) << p_owner);
            chk("rsp_err", rsp_err, p_err);
            chk("rsp_rdata", rsp_rdata, p_data);
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            busy = 0;
        end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("rsp_rdata_idle", rsp_rdata, 0);
            chk("rsp_err_idle", rsp_err, 0);
        end

        exp_rdy = 0;
        w = -1;
        if (was_idle && pv != 0) begin
            w = rr(pv, m_last);
            exp_rdy = 64'(1) << w;
        end
        chk("req_ready", req_ready, exp_rdy);

        if (w >= 0) begin
            chk("setup_psel", PSEL, 1);
            chk("setup_penable", PENABLE, 0);
            chk("setup_paddr", PADDR, ra[w]);
            chk("setup_pwrite", PWRITE, rw[w]);
            chk("setup_pwdata", PWDATA, rd[w]);
            m_last  = w;
            busy    = 1;
            p_owner = w;
            p_write = rw[w];
            p_addr  = ra[w];
            p_wdata = rd[w];
            nacc    = (stall_cfg + 1 > TO) ? TO : stall_cfg + 1;
            p_err   = (stall_cfg + 1 > TO);
            p_due   = cyc + 1 + nacc;
            p_data  = (p_write || p_err) ? '0 : m_mem[p_addr];
            if (p_write && !p_err) m_mem[p_addr] = p_wdata;
            grants.push_back(w);
        end else if (busy) begin
            chk("access_psel", PSEL, 1);
            chk("access_penable", PENABLE, 1);
            chk("access_paddr", PADDR, p_addr);
            chk("access_pwrite", PWRITE, p_write);
            chk("access_pwdata", PWDATA, p_wdata);
        end else begin
            chk("idle_psel", PSEL, 0);
            chk("idle_penable", PENABLE, 0);
        end

        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) rv[i] = 1'b0;
        end
    endtask

    task automatic run_until_idle(input int maxc);
        for (int k = 0; k < maxc && (busy || rv != 0); k++) tick();
        chk("drain", {busy, rv}, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_psel"}, PSEL, 0);
        chk({tag, "_penable"}, PENABLE, 0);
        chk({tag, "_pwrite"}, PWRITE, 0);
        chk({tag, "_paddr"}, PADDR, 0);
        chk({tag, "_pwdata"}, PWDATA, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
    endtask

    task automatic do_reset(input string tag);
        PRESETn = 1'b0;
        rv = '0;
        #1;
        check_outputs_zero(tag);
        busy = 0;
        m_last = NR - 1;
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rw[i] = wr;
        ra[i] = a;
        rd[i] = d;
        rv[i] = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        #2;
        do_reset("rst");

        // single write, then read it back
        stall_cfg = 0;
        set_req(0, 1, 4'd2, 32'hDEADBEEF);
        tick();
        chk("t1_ready", req_ready, 2'b01);
        chk("t1_paddr", PADDR, 2);
        chk("t1_penable_setup", PENABLE, 0);
        tick();
        chk("t1_penable_access", PENABLE, 1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_err", rsp_err, 0);
        set_req(0, 0, 4'd2, 32'h0);
        run_until_idle(20);
        chk("t1_readback", last_rdata, 32'hDEADBEEF);

        // simultaneous requests with immediate re-request: grants alternate
        do_reset("rst2");
        grants.delete();
        set_req(0, 1, 4'd0, 32'h11);
        set_req(1, 1, 4'd1, 32'h22);
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            tick();
            if (grants.size() < 4) rv = '1;
            else rv = '0;
        end
        run_until_idle(20);
        chk("t2_ngrants", grants.size(), 4);
        for (int k = 0; k < 4 && k < grants.size(); k++) chk("t2_order", grants[k], k % 2);
        set_req(0, 0, 4'd1, 32'h0);
        run_until_idle(20);
        chk("t2_read_a1", last_rdata, 32'h22);
        set_req(1, 0, 4'd0, 32'h0);
        run_until_idle(20);
        chk("t2_read_a0", last_rdata, 32'h11);

        // wait states: three stalled cycles, PREADY on the fourth
        set_req(1, 1, 4'd5, 32'h5A5A5A5A);
        run_until_idle(20);
        stall_cfg = 3;
        set_req(0, 0, 4'd5, 32'h0);
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_psel", PSEL, 1);
            chk("t3_penable", PENABLE, 1);
            chk("t3_paddr", PADDR, 5);
        end
        tick();
        chk("t3_rsp_valid", rsp_valid, 2'b01);
        chk("t3_rsp_err", rsp_err, 0);
        chk("t3_rsp_rdata", rsp_rdata, 32'h5A5A5A5A);

        // timeout with PREADY stuck low
        stall_cfg = 1000;
        set_req(1, 0, 4'd5, 32'h0);
        tick();
        for (int k = 0; k < TO; k++) begin
            tick();
            chk("t4_psel", PSEL, 1);
            chk("t4_penable", PENABLE, 1);
        end
        tick();
        chk("t4_psel_end", PSEL, 0);
        chk("t4_rsp_valid", rsp_valid, 2'b10);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        stall_cfg = 0;
        set_req(1, 0, 4'd5, 32'h0);
        run_until_idle(20);
        chk("t4_recover_data", last_rdata, 32'h5A5A5A5A);
        chk("t4_recover_err", last_err, 0);

        // reset during ACCESS
        stall_cfg = 1000;
        set_req(0, 0, 4'd5, 32'h0);
        tick();
        tick();
        chk("t5_in_access", PENABLE, 1);
        do_reset("t5_rst");
        stall_cfg = 0;
        repeat (3) tick();
        grants.delete();
        set_req(1, 0, 4'd3, 32'h0);
        run_until_idle(20);
        set_req(0, 1, 4'd3, 32'hA0A0A0A0);
        set_req(1, 1, 4'd4, 32'hB1B1B1B1);
        run_until_idle(30);
        chk("t5_ngrants", grants.size(), 3);
        if (grants.size() == 3) begin
            chk("t5_g0", grants[0], 1);
            chk("t5_g1", grants[1], 0);
            chk("t5_g2", grants[2], 1);
        end

        // withdrawn request from requester 1 during requester 0's ACCESS
        grants.delete();
        stall_cfg = 2;
        set_req(0, 1, 4'd7, 32'h01234567);
        tick();
        tick();
        set_req(1, 0, 4'd3, 32'h0);
        tick();
        rv[1] = 1'b0;
        run_until_idle(20);
        repeat (3) tick();
        chk("t6_ngrants", grants.size(), 1);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!busy) stall_cfg = $urandom_range(0, 5);
            for (int i = 0; i < NR; i++) begin
                if (!rv[i]) begin
                    if ($urandom_range(0, 2) == 0)
                        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    rv[i] = 1'b0;
                end
            end
            tick();
        end
        rv = '0;
        run_until_idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- Multi-requester APB master that shares one APB completer port between NUM_REQ internal requesters.
- Arbitrates round-robin, sequences the APB SETUP and ACCESS phases, and waits on PREADY.
- Returns read data or a timeout error to the winning requester.
- Sits between firmware or DMA request sources and the peripheral register blocks (4-register APB slaves, PREADY may stall).

Parameters:
- ADDR_WIDTH, 4, APB address width.
- DATA_WIDTH, 32, APB data width.
- NUM_REQ, 2, number of requesters (≥2).
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort. 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse; one-hot or zero.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester; one-hot or zero.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Reset values: all outputs registered and 0 during reset; FSM=IDLE; rr pointer last_grant=NUM_REQ-1, so requester 0 has first priority; wait counter=0.
- Reset mid-transfer: asserting PRESETn low clears everything immediately (async). No rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE, no req_valid: PSEL=PENABLE=0; stay in IDLE.
- IDLE with any req_valid:
  - Grant g = first asserted index searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Same edge: latch req_write/addr/wdata[g] into PWRITE/PADDR/PWDATA, set PSEL=1, PENABLE=0, owner=g, last_grant=g, pulse req_ready[g] for one cycle, go to SETUP.
- SETUP: one cycle only. Next edge sets PENABLE=1 and clears the wait counter; go to ACCESS.
- ACCESS with PREADY=1:
  - Next edge: PSEL=PENABLE=0, rsp_valid[owner]=1 for one cycle, rsp_err=0.
  - rsp_rdata = PRDATA for reads, 0 for writes; go to IDLE.
- ACCESS with PREADY=0: increment the wait counter.
  - Timeout fires when TIMEOUT≠0 and the counter reaches TIMEOUT-1 with PREADY still 0, i.e. on the TIMEOUT-th stalled cycle.
  - On timeout: next edge PSEL=PENABLE=0, rsp_valid[owner]=1, rsp_err=1, rsp_rdata=0; go to IDLE.
- PREADY high on the timeout cycle: normal completion wins and rsp_err=0.
- APB stability: PADDR/PWRITE/PWDATA stay constant from SETUP until the completing edge. They hold their last value in IDLE.
- Throughput: 3 cycles per zero-wait transfer (IDLE→SETUP→ACCESS). rsp_valid coincides with the next IDLE cycle, so a new grant may happen in that same cycle.
- Requester contract:
  - Hold req_* stable while req_valid=1 until req_ready.
  - Dropping req_valid before grant is legal and issues nothing.
  - A requester may re-request right after req_ready, but that request is not granted before the current transfer completes.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ-1 transfers.
- rsp_rdata/rsp_err are 0 whenever rsp_valid is all-zero.

Test Plan:
- Reset then single write: req0 write addr=2, wdata=0xDEADBEEF. Expect req_ready[0] pulse, then SETUP (PSEL=1,PENABLE=0,PADDR=2), then ACCESS (PENABLE=1). With PREADY=1, rsp_valid=01, rsp_err=0; a follow-up read of addr 2 returns rsp_rdata=0xDEADBEEF.
- Simultaneous requests: req0 and req1 both valid from reset, writing 0x11 to addr 0 and 0x22 to addr 1. Expect grant order req0 then req1; then with both re-requesting, req0 then req1 again (alternating); no back-to-back grant to the same requester while the other is waiting.
- Wait states: stub holds PREADY=0 for 3 ACCESS cycles then 1, PRDATA=0x5A5A5A5A. Expect PSEL/PENABLE/PADDR stable for 4 ACCESS cycles, rsp_rdata=0x5A5A5A5A, rsp_err=0.
- Timeout: TIMEOUT=4, PREADY stuck at 0. Expect exactly 4 ACCESS cycles, then PSEL=0, rsp_valid for the owner with rsp_err=1, rsp_rdata=0. A next request proceeds normally once PREADY is restored.
- Reset mid-transfer: assert PRESETn=0 during ACCESS. Expect all outputs 0 immediately, no rsp_valid. After release, req1 alone is granted, and next req0+req1 together grants req0 first (pointer reset).
- Request withdrawal: req1 raises req_valid for 1 cycle while req0's transfer is in ACCESS, then drops. Expect no grant to req1 and no APB activity after req0 completes.
